axi_lite_master_ctrl: RTL
=========================

// Module: axi_lite_master_ctrl
// PURPOSE
//  Single-outstanding AXI4-Lite master sequencer that turns a simple command/response interface into AXI4-Lite reads and writes.
//  It drives the register-file slave (4 x 32-bit regs at 0x0/0x4/0x8/0xC) from a local controller or test sequencer.
//  Each write sequences AW+W, then B. Each read sequences AR, then R. Only one transaction is in flight at a time.
// PARAMETERS
//  ADDR_W  32      address width of cmd_addr and m_axi_awaddr/araddr
//  DATA_W  32      data width; strobe width is DATA_W/8
//  PROT    3'b000  constant driven on m_axi_awprot and m_axi_arprot
// PORTS
//  aclk            in   1         clock, all logic on rising edge
//  aresetn         in   1         asynchronous active-low reset
//  cmd_valid       in   1         command request
//  cmd_ready       out  1         controller idle, can accept a command
//  cmd_write       in   1         1=write, 0=read
//  cmd_addr        in   ADDR_W    byte address; bits [1:0] forced to 0 on the bus
//  cmd_wdata       in   DATA_W    write data
//  cmd_wstrb       in   DATA_W/8  write byte strobes
//  rsp_valid       out  1         one-cycle pulse: transaction complete
//  rsp_rdata       out  DATA_W    read data (0 for writes)
//  rsp_resp        out  2         BRESP/RRESP returned by the slave
//  m_axi_awaddr    out  ADDR_W    write address
//  m_axi_awprot    out  3         = PROT
//  m_axi_awvalid   out  1         write address valid
//  m_axi_awready   in   1         write address ready
//  m_axi_wdata     out  DATA_W    write data
//  m_axi_wstrb     out  DATA_W/8  write strobes
//  m_axi_wvalid    out  1         write data valid
//  m_axi_wready    in   1         write data ready
//  m_axi_bresp     in   2         write response
//  m_axi_bvalid    in   1         write response valid
//  m_axi_bready    out  1         write response ready
//  m_axi_araddr    out  ADDR_W    read address
//  m_axi_arprot    out  3         = PROT
//  m_axi_arvalid   out  1         read address valid
//  m_axi_arready   in   1         read address ready
//  m_axi_rdata     in   DATA_W    read data
//  m_axi_rresp     in   2         read response
//  m_axi_rvalid    in   1         read data valid
//  m_axi_rready    out  1         read data ready
// BEHAVIOUR
//  Reset (async, aresetn=0): state=IDLE. All valids/readies, cmd_ready, rsp_valid=0. rsp_rdata, rsp_resp, bus addr/data/strb=0. An in-flight transaction is abandoned with no rsp.
//  cmd_ready is registered. It rises the first clock after reset release and whenever state returns to IDLE.
//  FSM states: IDLE -> WR_AW_W -> WR_B -> IDLE; IDLE -> RD_AR -> RD_R -> IDLE.
//  IDLE: on cmd_valid&&cmd_ready, register addr/wdata/wstrb/write, clear cmd_ready, go to WR_AW_W or RD_AR.
//    The matching valids (awvalid+wvalid, or arvalid) are 1 the next cycle.
//  WR_AW_W: awvalid and wvalid are held independently until their own handshake, then each drops.
//    Go to WR_B when both have handshaken. AW and W in the same cycle is legal and goes straight to WR_B.
//  WR_B: bready=1. On bvalid, capture bresp and go to IDLE. bvalid seen outside WR_B is ignored (bready=0).
//  RD_AR: arvalid held until arready, then go to RD_R.
//  RD_R: rready=1. On rvalid, capture rdata/rresp and go to IDLE.
//  Completion: the cycle after the B/R handshake, rsp_valid=1 for exactly 1 cycle and cmd_ready=1 in that same cycle.
//    rsp_rdata/rsp_resp hold until the next completion. rsp_rdata=0 after a write.
//  Bus outputs are stable while valid is high (AXI rule); valid never deasserts without a handshake.
//  Minimum latency with an always-ready slave that answers next cycle: accept@0, bus valid@1, B/R@2, rsp_valid@3.
//  wstrb=0 is still issued. SLVERR/DECERR are passed through unchanged; no retry.
//  cmd_valid while cmd_ready=0 is ignored; no queueing.
// TESTING
//  Write 0x4 <- 0xDEADBEEF, strb 0xF, slave always ready, bresp=0 -> aw/w valid@1 with awaddr=0x4; rsp_valid@3, rsp_resp=0.
//  Read 0x8, slave returns 0x12345678 rresp=0 -> araddr=0x8, rsp_valid pulse with rsp_rdata=0x12345678, cmd_ready same cycle.
//  Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, single B, single rsp.
//  Read with rresp=2'b10, cmd_addr=0x7 -> araddr=0x4, rsp_resp=2'b10, rsp_rdata=bus rdata.
//  aresetn low while in WR_B -> all outputs 0 immediately; after release cmd_ready=1 next clock, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: converts a command/response handshake into
// one AXI4-Lite write (AW+W then B) or read (AR then R) at a time.
module axi_lite_master_ctrl #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [2:0]            fsm_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid && ready; a raised valid and its payload hold steady until that edge.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] aligned_addr;

  assign aligned_addr = cmd_addr & ~ADDR_W'(3);
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;
  assign fsm_state    = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= aligned_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_AW_W;
            end else begin
              m_axi_araddr  <= aligned_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_AW_W: begin
          // A channel whose valid is already low has completed its handshake.
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            cmd_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        RD_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_valid    <= 1'b1;
            cmd_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
